commit_trace_buffer: RTL and testbench

Synthesizable retirement-trace capture buffer for the RISC-V cores. It records one entry per committed instruction: pc, instr, register writeback and memory write, all taken from the core's commit/debug outputs. It supports a PC trigger, stop-when-full and wrap-around capture modes, and a drop counter. Entries drain through a valid/ready port to a debug/UART bridge, so the trace can be taken on silicon and FPGA instead of only in simulation logging.

---
 rtl/riscv_pkg.sv | 23 ++
 rtl/trace_fifo.sv | 81 ++++++++
 rtl/commit_trace_buffer.sv | 114 +++++++++++
 tb/tb_commit_trace_buffer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions; the trace types here describe one retired instruction
// as captured by commit_trace_buffer.
package riscv_pkg;

    localparam int XLEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic [4:0]      reg_addr;
        logic [XLEN-1:0] reg_data;
        logic            mem_wrt;
        logic [XLEN-1:0] mem_addr;
        logic [XLEN-1:0] mem_data;
    } trace_entry_t;

    typedef enum logic [1:0] {
        TRACE_IDLE    = 2'd0,
        TRACE_ARMED   = 2'd1,
        TRACE_CAPTURE = 2'd2
    } trace_state_e;

endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through circular buffer of trace entries; when full it can optionally
// overwrite its oldest entry instead of refusing a push.
module trace_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       overwrite_oldest_i,
    input  trace_entry_t               wdata_i,
    output trace_entry_t               rdata_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    trace_entry_t    mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_pop, do_push, do_overwrite;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // An overwrite is a push into a full buffer with no pop to make room.
    assign do_pop       = pop_i && !empty_o;
    assign do_overwrite = push_i && full_o && !do_pop && overwrite_oldest_i;
    assign do_push      = push_i && (!full_o || do_pop || overwrite_oldest_i);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (do_pop || do_overwrite) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (do_push && !do_overwrite && !do_pop) begin
                count_d = count_q + CW'(1);
            end else if (do_pop && !do_push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i && !rst_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/commit_trace_buffer.sv
// Retirement trace capture: arm/trigger/stop control, drop accounting and a drain port
// in front of a trace_fifo.
module commit_trace_buffer
    import riscv_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DROP_W = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       update_i,
    input  logic [XLEN-1:0]            pc_i,
    input  logic [XLEN-1:0]            instr_i,
    input  logic [4:0]                 reg_addr_i,
    input  logic [XLEN-1:0]            reg_data_i,
    input  logic                       mem_wrt_i,
    input  logic [XLEN-1:0]            mem_addr_i,
    input  logic [XLEN-1:0]            mem_data_i,
    input  logic                       arm_i,
    input  logic                       stop_i,
    input  logic                       trig_en_i,
    input  logic [XLEN-1:0]            trig_pc_i,
    input  logic                       wrap_mode_i,
    output logic                       rd_valid_o,
    input  logic                       rd_ready_i,
    output trace_entry_t               rd_entry_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic [DROP_W-1:0]          drop_cnt_o,
    output logic [1:0]                 state_o
);

    trace_state_e      state_q, state_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              trig_hit, push_req, pop, fifo_full, fifo_empty, drop_event;
    trace_entry_t      wr_entry;

    assign wr_entry = '{pc: pc_i, instr: instr_i, reg_addr: reg_addr_i, reg_data: reg_data_i,
                        mem_wrt: mem_wrt_i, mem_addr: mem_addr_i, mem_data: mem_data_i};

    assign trig_hit   = !trig_en_i || (pc_i == trig_pc_i);
    assign rd_valid_o = !fifo_empty;
    assign pop        = rd_valid_o && rd_ready_i;

    // arm_i flushes and re-arms regardless of state, so it masks any coincident push.
    always_comb begin
        state_d  = state_q;
        push_req = 1'b0;
        if (arm_i) begin
            state_d = TRACE_ARMED;
        end else begin
            unique case (state_q)
                TRACE_IDLE: begin
                    state_d = TRACE_IDLE;
                end
                TRACE_ARMED: begin
                    if (stop_i) begin
                        state_d = TRACE_IDLE;
                    end else if (update_i && trig_hit) begin
                        state_d  = TRACE_CAPTURE;
                        push_req = 1'b1;
                    end
                end
                TRACE_CAPTURE: begin
                    push_req = update_i;
                    if (stop_i) begin
                        state_d = TRACE_IDLE;
                    end
                end
                default: state_d = TRACE_IDLE;
            endcase
        end
    end

    // Both full-buffer policies lose one commit when nothing is popped: either the
    // new entry or the oldest one.
    assign drop_event = push_req && fifo_full && !pop;

    always_comb begin
        drop_d = drop_q;
        if (arm_i) begin
            drop_d = '0;
        end else if (drop_event && (drop_q != '1)) begin
            drop_d = drop_q + DROP_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= TRACE_IDLE;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
        end
    end

    trace_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .flush_i            (arm_i),
        .push_i             (push_req),
        .pop_i              (pop),
        .overwrite_oldest_i (wrap_mode_i),
        .wdata_i            (wr_entry),
        .rdata_o            (rd_entry_o),
        .count_o            (count_o),
        .full_o             (fifo_full),
        .empty_o            (fifo_empty)
    );

    assign drop_cnt_o = drop_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed and random stimulus for commit_trace_buffer (DEPTH=4), checked every cycle
// against a queue-based model of the capture rules.
module tb_commit_trace_buffer;
    import riscv_pkg::*;

    localparam int DEPTH  = 4;
    localparam int DROP_W = 16;
    localparam int M_IDLE = 0, M_ARMED = 1, M_CAPT = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              update = 1'b0, arm = 1'b0, stop = 1'b0;
    logic              trig_en = 1'b0, wrap = 1'b0, ready = 1'b0;
    logic [XLEN-1:0]   trig_pc = '0;
    trace_entry_t      in_e = '0;
    logic              rd_valid;
    trace_entry_t      rd_entry;
    logic [2:0]        count;
    logic [DROP_W-1:0] drop_cnt;
    logic [1:0]        state;

    int total = 0;
    int bad   = 0;

    trace_entry_t mq[$];
    int           m_state = M_IDLE;
    int           m_drop  = 0;
    logic [XLEN-1:0] got[$];

    commit_trace_buffer #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .update_i    (update),
        .pc_i        (in_e.pc),
        .instr_i     (in_e.instr),
        .reg_addr_i  (in_e.reg_addr),
        .reg_data_i  (in_e.reg_data),
        .mem_wrt_i   (in_e.mem_wrt),
        .mem_addr_i  (in_e.mem_addr),
        .mem_data_i  (in_e.mem_data),
        .arm_i       (arm),
        .stop_i      (stop),
        .trig_en_i   (trig_en),
        .trig_pc_i   (trig_pc),
        .wrap_mode_i (wrap),
        .rd_valid_o  (rd_valid),
        .rd_ready_i  (ready),
        .rd_entry_o  (rd_entry),
        .count_o     (count),
        .drop_cnt_o  (drop_cnt),
        .state_o     (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour: the buffer is a bounded queue of at most DEPTH entries.
    task automatic model_step();
        bit do_pop, do_push;
        if (rst) begin
            mq.delete(); m_state = M_IDLE; m_drop = 0;
            return;
        end
        if (arm) begin
            mq.delete(); m_drop = 0; m_state = M_ARMED;
            return;
        end
        do_pop  = (mq.size() > 0) && ready;
        do_push = 1'b0;
        if (m_state == M_ARMED) begin
            if (stop) m_state = M_IDLE;
            else if (update && (!trig_en || in_e.pc == trig_pc)) begin
                do_push = 1'b1; m_state = M_CAPT;
            end
        end else if (m_state == M_CAPT) begin
            do_push = update;
            if (stop) m_state = M_IDLE;
        end
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
            if (mq.size() < DEPTH) begin
                mq.push_back(in_e);
            end else begin
                if (wrap) begin
                    void'(mq.pop_front());
                    mq.push_back(in_e);
                end
                if (m_drop < (1 << DROP_W) - 1) m_drop++;
            end
        end
    endtask

    task automatic check_all();
        chk("state", state, m_state);
        chk("count", count, mq.size());
        chk("drop", drop_cnt, m_drop);
        chk("valid", rd_valid, mq.size() > 0);
        if (mq.size() > 0) chk("head", rd_entry, mq[0]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    function automatic trace_entry_t rand_entry(input logic [XLEN-1:0] pc);
        trace_entry_t e;
        e.pc       = pc;
        e.instr    = $urandom;
        e.reg_addr = 5'($urandom);
        e.reg_data = $urandom;
        e.mem_wrt  = 1'($urandom);
        e.mem_addr = $urandom;
        e.mem_data = $urandom;
        return e;
    endfunction

    task automatic commit(input logic [XLEN-1:0] pc);
        in_e = rand_entry(pc); update = 1'b1;
        tick();
        update = 1'b0;
    endtask

    task automatic do_arm();
        arm = 1'b1; tick(); arm = 1'b0;
    endtask

    // Drains with a cycle budget; pcs are recorded before the popping edge.
    task automatic drain();
        got.delete();
        ready = 1'b1; update = 1'b0;
        for (int i = 0; i < DEPTH + 4; i++) begin
            if (!rd_valid) break;
            got.push_back(rd_entry.pc);
            tick();
        end
        chk("drain_done", rd_valid, 1'b0);
        ready = 1'b0;
    endtask

    task automatic chk_pcs(input string tag, input logic [XLEN-1:0] p0, input logic [XLEN-1:0] p1,
                           input logic [XLEN-1:0] p2, input logic [XLEN-1:0] p3, input int n);
        logic [XLEN-1:0] exp[4];
        exp = '{p0, p1, p2, p3};
        chk({tag, "_n"}, got.size(), n);
        for (int i = 0; i < n && i < got.size(); i++) chk({tag, "_pc"}, got[i], exp[i]);
    endtask

    initial begin
        // Reset and idle
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) commit(32'h40 + 32'(4 * i));
        chk("idle_count", count, 0);
        chk("idle_valid", rd_valid, 0);
        chk("idle_drop", drop_cnt, 0);
        chk("idle_state", state, 0);

        // Trigger on pc 0x8000_0010
        trig_en = 1'b1; trig_pc = 32'h8000_0010;
        do_arm();
        chk("armed_state", state, 1);
        for (int i = 0; i < 6; i++) begin
            commit(32'h8000_0000 + 32'(4 * i));
            if (i == 3) chk("pre_trig_state", state, 1);
            if (i == 4) chk("trig_state", state, 2);
        end
        chk("trig_count", count, 2);
        drain();
        chk_pcs("trig", 32'h8000_0010, 32'h8000_0014, 0, 0, 2);
        stop = 1'b1; tick(); stop = 1'b0;

        // Stop-when-full
        trig_en = 1'b0; wrap = 1'b0;
        do_arm();
        for (int i = 0; i < 6; i++) commit(32'h100 + 32'(4 * i));
        chk("swf_count", count, 4);
        chk("swf_drop", drop_cnt, 2);
        drain();
        chk_pcs("swf", 32'h100, 32'h104, 32'h108, 32'h10C, 4);

        // Wrap
        wrap = 1'b1;
        do_arm();
        for (int i = 0; i < 6; i++) commit(32'h100 + 32'(4 * i));
        chk("wrap_count", count, 4);
        chk("wrap_drop", drop_cnt, 2);
        drain();
        chk_pcs("wrap", 32'h108, 32'h10C, 32'h110, 32'h114, 4);

        // Full with simultaneous pop
        wrap = 1'b0;
        do_arm();
        for (int i = 0; i < 4; i++) commit(32'h300 + 32'(4 * i));
        ready = 1'b1;
        commit(32'h200);
        ready = 1'b0;
        chk("fpop_count", count, 4);
        chk("fpop_drop", drop_cnt, 0);
        drain();
        chk_pcs("fpop", 32'h304, 32'h308, 32'h30C, 32'h200, 4);

        // Re-arm priority: count 3 with one drop, then arm+stop+update together
        do_arm();
        for (int i = 0; i < 5; i++) commit(32'h400 + 32'(4 * i));
        ready = 1'b1; tick(); ready = 1'b0;
        chk("rearm_pre_count", count, 3);
        chk("rearm_pre_drop", drop_cnt, 1);
        arm = 1'b1; stop = 1'b1;
        commit(32'h500);
        arm = 1'b0; stop = 1'b0;
        chk("rearm_count", count, 0);
        chk("rearm_drop", drop_cnt, 0);
        chk("rearm_state", state, 1);
        chk("rearm_valid", rd_valid, 0);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            rst     = ($urandom_range(0, 199) == 0);
            arm     = ($urandom_range(0, 39) == 0);
            stop    = ($urandom_range(0, 29) == 0);
            update  = ($urandom_range(0, 2) != 0);
            ready   = ($urandom_range(0, 2) == 0);
            wrap    = 1'($urandom);
            trig_en = 1'($urandom);
            trig_pc = 32'h1000 + 32'(4 * $urandom_range(0, 3));
            in_e    = rand_entry(32'h1000 + 32'(4 * $urandom_range(0, 7)));
            tick();
        end
        rst = 1'b0; arm = 1'b0; stop = 1'b0; update = 1'b0; ready = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
